// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for the iterative FP divider.
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_z;
  logic [4:0]   o_flags;

  modport master (output i_valid, i_a, i_b, i_ready,
                  input  o_ready, o_valid, o_z, o_flags);
  modport slave  (input  i_valid, i_a, i_b, i_ready,
                  output o_ready, o_valid, o_z, o_flags);
endinterface

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider z = a / b: restoring significand division, RNE,
// subnormals flushed to zero, one operation in flight.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BPC   = 1
) (
  input  logic         clk,
  input  logic         reset,
  fp_div_iter_if.slave io
);
  localparam int W    = EXP_W + MAN_W + 1;
  localparam int SW   = MAN_W + 1;
  localparam int ITER = (MAN_W + 3 + BPC - 1) / BPC;
  localparam int QW   = ITER * BPC;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, NORM, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            o_valid_q, o_valid_d;
  logic            o_ready_q, o_ready_d;
  logic [W-1:0]    o_z_q, o_z_d;
  logic [4:0]      o_flags_q, o_flags_d;

  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [SW-1:0]        mb_q, mb_d;
  logic [SW:0]          rem_q, rem_d;
  logic [QW-1:0]        quo_q, quo_d;
  logic                 spec_q, spec_d;
  logic [W-1:0]         spec_z_q, spec_z_d;
  logic [4:0]           spec_flags_q, spec_flags_d;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic [SW:0]          r;
  logic [QW-1:0]        q, qn;
  logic signed [EW-1:0] e0, e1;
  logic [SW-1:0]        sig;
  logic                 g, st, carry;
  logic [SW:0]          sum;
  logic [MAN_W-1:0]     mant;
  logic [W+4:0]         res;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  // Exponent zero covers both true zeros and flushed subnormals.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  function automatic logic [SW:0] round_rne(input logic [SW-1:0] s, input logic gd,
                                            input logic sk);
    logic inc;
    inc = gd & (sk | s[0]);
    return {1'b0, s} + {{SW{1'b0}}, inc};
  endfunction

  function automatic logic [W+4:0] saturate(input logic s, input logic signed [EW-1:0] e,
                                            input logic [MAN_W-1:0] m, input logic inx);
    if (e >= $signed(EW'(EMAX))) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 5'b00101};
    if (e <= $signed(EW'(0)))    return {s, {(W-1){1'b0}}, 5'b00011};
    return {s, e[EXP_W-1:0], m, 4'b0000, inx};
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_valid_d    = o_valid_q;
    o_z_d        = o_z_q;
    o_flags_d    = o_flags_q;
    a_d          = a_q;
    b_d          = b_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    mb_d         = mb_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    spec_d       = spec_q;
    spec_z_d     = spec_z_q;
    spec_flags_d = spec_flags_q;
    r            = rem_q;
    q            = quo_q;

    // Normalisation and rounding of the finished quotient.
    qn    = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
    e0    = quo_q[QW-1] ? exp_q : exp_q - $signed(EW'(1));
    sig   = qn[QW-1 -: SW];
    g     = qn[QW-1-SW];
    st    = (|qn[QW-2-SW:0]) | (|rem_q);
    sum   = round_rne(sig, g, st);
    carry = sum[SW];
    mant  = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    e1    = e0 + $signed({{(EW-1){1'b0}}, carry});
    res   = saturate(sign_q, e1, mant, g | st);

    case (state_q)
      IDLE: begin
        if (io.i_valid) begin
          a_d     = io.i_a;
          b_d     = io.i_b;
          state_d = PREP;
        end
      end
      PREP: begin
        sign_d       = sa ^ sb;
        exp_d        = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(EW'(BIAS));
        mb_d         = {1'b1, fb};
        rem_d        = {2'b01, fa};
        quo_d        = '0;
        cnt_d        = '0;
        spec_d       = 1'b1;
        spec_flags_d = 5'b00000;
        // Specials bypass DIV and pick up their result in NORM.
        state_d      = NORM;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_z_d     = QNAN;
          spec_flags_d = {(a_zero && b_zero) || (a_inf && b_inf), 4'b0000};
        end else if (a_inf) begin
          spec_z_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
          spec_z_d     = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          spec_flags_d = 5'b01000;
        end else if (a_zero || b_inf) begin
          spec_z_d = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
          spec_d  = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        for (int i = 0; i < BPC; i++) begin
          if (r >= {1'b0, mb_q}) begin
            r = r - {1'b0, mb_q};
            q = {q[QW-2:0], 1'b1};
          end else begin
            q = {q[QW-2:0], 1'b0};
          end
          r = r << 1;
        end
        rem_d = r;
        quo_d = q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = NORM;
      end
      NORM: begin
        state_d   = DONE;
        o_valid_d = 1'b1;
        o_z_d     = spec_q ? spec_z_q : res[W+4:5];
        o_flags_d = spec_q ? spec_flags_q : res[4:0];
      end
      DONE: begin
        if (io.i_ready) begin
          state_d   = IDLE;
          o_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    o_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b1;
      o_z_q     <= '0;
      o_flags_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_ready_q <= o_ready_d;
      o_z_q     <= o_z_d;
      o_flags_q <= o_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q          <= a_d;
    b_q          <= b_d;
    sign_q       <= sign_d;
    exp_q        <= exp_d;
    mb_q         <= mb_d;
    rem_q        <= rem_d;
    quo_q        <= quo_d;
    spec_q       <= spec_d;
    spec_z_q     <= spec_z_d;
    spec_flags_q <= spec_flags_d;
  end

  assign io.o_ready = o_ready_q;
  assign io.o_valid = o_valid_q;
  assign io.o_z     = o_z_q;
  assign io.o_flags = o_flags_q;
endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: SP (1 and 2 bits/cycle) and DP builds.
module tb_fp_div_iter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_div_iter_if #(.EXP_W(8),  .MAN_W(23)) if_sp  ();
  fp_div_iter_if #(.EXP_W(8),  .MAN_W(23)) if_sp2 ();
  fp_div_iter_if #(.EXP_W(11), .MAN_W(52)) if_dp  ();

  fp_div_iter #(.EXP_W(8),  .MAN_W(23), .BPC(1)) u_sp  (.clk(clk), .reset(reset), .io(if_sp.slave));
  fp_div_iter #(.EXP_W(8),  .MAN_W(23), .BPC(2)) u_sp2 (.clk(clk), .reset(reset), .io(if_sp2.slave));
  fp_div_iter #(.EXP_W(11), .MAN_W(52), .BPC(1)) u_dp  (.clk(clk), .reset(reset), .io(if_dp.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[15];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b);
    case (sel)
      0: begin if_sp.i_valid = v;  if_sp.i_a = a[31:0];  if_sp.i_b = b[31:0];  end
      1: begin if_sp2.i_valid = v; if_sp2.i_a = a[31:0]; if_sp2.i_b = b[31:0]; end
      default: begin if_dp.i_valid = v; if_dp.i_a = a; if_dp.i_b = b; end
    endcase
  endtask

  task automatic set_rdy(input int sel, input logic r);
    case (sel)
      0: if_sp.i_ready = r;
      1: if_sp2.i_ready = r;
      default: if_dp.i_ready = r;
    endcase
  endtask

  function automatic logic get_valid(input int sel);
    case (sel)
      0: return if_sp.o_valid;
      1: return if_sp2.o_valid;
      default: return if_dp.o_valid;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0: return if_sp.o_ready;
      1: return if_sp2.o_ready;
      default: return if_dp.o_ready;
    endcase
  endfunction

  function automatic logic [63:0] get_z(input int sel);
    case (sel)
      0: return {32'b0, if_sp.o_z};
      1: return {32'b0, if_sp2.o_z};
      default: return if_dp.o_z;
    endcase
  endfunction

  function automatic logic [4:0] get_f(input int sel);
    case (sel)
      0: return if_sp.o_flags;
      1: return if_sp2.o_flags;
      default: return if_dp.o_flags;
    endcase
  endfunction

  task automatic run_op(input string name, input int sel, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] z_exp,
                        input logic [4:0] f_exp, input int lat_exp, input int hold);
    int lat;
    int w;
    w = 0;
    while (!get_ready(sel) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!get_ready(sel)) begin
      check({name, "_ready_timeout"}, 64'(get_ready(sel)), 64'd1);
      return;
    end
    set_in(sel, 1'b1, a, b);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 64'd0, 64'd0);
    lat = 0;
    while (!get_valid(sel) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_z"}, get_z(sel), z_exp);
    check({name, "_flags"}, 64'(get_f(sel)), 64'(f_exp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({name, "_hold_ctl"}, 64'({get_valid(sel), get_ready(sel), get_f(sel)}),
            64'({1'b1, 1'b0, f_exp}));
      check({name, "_hold_z"}, get_z(sel), z_exp);
    end
    set_rdy(sel, 1'b1);
    @(posedge clk); #1;
    set_rdy(sel, 1'b0);
    check({name, "_idle"}, 64'({get_ready(sel), get_valid(sel)}), 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 64'd0, 64'd0);
      set_rdy(s, 1'b0);
    end
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2};
    vecs[4]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2};
    vecs[5]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28};
    vecs[6]  = '{32'h80800000, 32'h40000000, 32'h80000000, 5'b00011, 28};
    vecs[7]  = '{32'hC0A00000, 32'h40000000, 32'hC0200000, 5'b00000, 28};
    vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 2};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2};
    vecs[10] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b00000, 2};
    vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2};
    vecs[12] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000, 2};
    vecs[13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28};
    vecs[14] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 5'b00001, 28};

    #1 reset = 1'b0;
    #1;
    check("reset_valid", 64'(if_sp.o_valid), 64'd0);
    check("reset_z", 64'(if_sp.o_z), 64'd0);
    check("reset_flags", 64'(if_sp.o_flags), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", 64'(if_sp.o_ready), 64'd1);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), 0, 64'(vecs[i].a), 64'(vecs[i].b),
             64'(vecs[i].z), vecs[i].f, vecs[i].lat, 0);

    run_op("backpressure", 0, 64'h40C00000, 64'h40000000, 64'h40400000, 5'b00000, 28, 10);
    run_op("back_to_back", 0, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'b00001, 28, 0);
    run_op("bpc2_third", 1, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'b00001, 15, 0);
    run_op("dp_third", 2, 64'h3FF0000000000000, 64'h4008000000000000,
           64'h3FD5555555555555, 5'b00001, 57, 0);

    // Reset during the division phase drops the op and clears outputs asynchronously.
    set_in(0, 1'b1, 64'h40C00000, 64'h40000000);
    @(posedge clk); #1;
    set_in(0, 1'b0, 64'd0, 64'd0);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_valid", 64'(if_sp.o_valid), 64'd0);
    check("midrst_z", 64'(if_sp.o_z), 64'd0);
    check("midrst_flags", 64'(if_sp.o_flags), 64'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 64'(if_sp.o_ready), 64'd1);
    run_op("after_reset", 0, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'b00001, 28, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
